// File: rtl/shift_rotate_seq_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit: op codes, FSM states
// and the op legality check.
package shift_rotate_seq_pkg;

    typedef enum logic [2:0] {
        OP_SHR  = 3'b000,
        OP_SHRA = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/shift_rotate_seq_step.sv
// Combinational single-step shifter: moves WIDTH bits by k (0..STEP) in the
// selected mode. Illegal ops pass the data through untouched.
module shift_rotate_seq_step
    import shift_rotate_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (op)
            OP_SHR:  data_out = data_in >> k;
            OP_SHRA: data_out = $unsigned($signed(data_in) >>> k);
            OP_SHL:  data_out = data_in << k;
            // Rotates use a doubled copy so bits shifted out re-enter at the far end.
            OP_ROR:  data_out = WIDTH'({data_in, data_in} >> k);
            OP_ROL:  data_out = WIDTH'(({data_in, data_in} << k) >> WIDTH);
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate unit: accepts an operand and count on start, shifts
// up to STEP bits per cycle, then presents a held result with a one-cycle done.
module shift_rotate_seq
    import shift_rotate_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] count_in,
    output logic             busy,
    output logic             done,
    output logic             op_err,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               op_err_q, op_err_d;

    logic               legal;
    logic [CNT_W-1:0]   eff;
    logic [CNT_W-1:0]   k;
    logic [WIDTH-1:0]   step_out;

    // Effective amount: linear shifts saturate at WIDTH, rotates wrap modulo WIDTH.
    always_comb begin
        legal = op_legal(op);
        eff   = '0;
        if (!legal) begin
            eff = '0;
        end else if (op == OP_ROR || op == OP_ROL) begin
            eff = CNT_W'(count_in % WIDTH_V);
        end else if (count_in >= WIDTH_V) begin
            eff = WIDTH_C;
        end else begin
            eff = CNT_W'(count_in);
        end
        k = (rem_q < STEP_C) ? rem_q : STEP_C;
    end

    shift_rotate_seq_step #(
        .WIDTH (WIDTH),
        .KW    (CNT_W)
    ) u_step (
        .op       (op_q),
        .data_in  (work_q),
        .k        (k),
        .data_out (step_out)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        work_d   = work_q;
        op_d     = op_q;
        result_d = result_q;
        op_err_d = op_err_q;
        case (state_q)
            ST_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - k;
                if (rem_q <= STEP_C) begin
                    state_d  = ST_DONE;
                    result_d = step_out;
                    op_err_d = 1'b0;
                end
            end
            ST_IDLE, ST_DONE: begin
                state_d  = ST_IDLE;
                op_err_d = 1'b0;
                if (start) begin
                    op_d   = op;
                    work_d = operand_a;
                    rem_d  = eff;
                    // Zero-distance and illegal ops finish without a SHIFT cycle.
                    if (eff == '0) begin
                        state_d  = ST_DONE;
                        result_d = operand_a;
                        op_err_d = !legal;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            work_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            work_q   <= work_d;
            op_q     <= op_d;
            result_q <= result_d;
            op_err_q <= op_err_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign op_err = op_err_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed scoreboard bench for shift_rotate_seq: one STEP=1 and one STEP=8 instance.
module tb_shift_rotate_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear1, start1, busy1, done1, err1;
    logic [2:0]   op1;
    logic [W-1:0] a1, c1, res1;
    logic         clear8, start8, busy8, done8, err8;
    logic [2:0]   op8;
    logic [W-1:0] a8, c8, res8;

    exp_t q1[$];
    exp_t q8[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    shift_rotate_seq #(.WIDTH(W), .STEP(1)) dut1 (
        .clock(clock), .clear(clear1), .start(start1), .op(op1),
        .operand_a(a1), .count_in(c1), .busy(busy1), .done(done1),
        .op_err(err1), .result(res1)
    );

    shift_rotate_seq #(.WIDTH(W), .STEP(8)) dut8 (
        .clock(clock), .clear(clear8), .start(start8), .op(op8),
        .operand_a(a8), .count_in(c8), .busy(busy8), .done(done8),
        .op_err(err8), .result(res8)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard pop on every done cycle of each instance.
    always @(negedge clock) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", W'(1), W'(0));
            end else begin
                e = q1.pop_front();
                check("dut1_result", res1, e.res);
                check("dut1_op_err", W'(err1), W'(e.err));
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("dut8_unexpected_done", W'(1), W'(0));
            end else begin
                e = q8.pop_front();
                check("dut8_result", res8, e.res);
                check("dut8_op_err", W'(err8), W'(e.err));
            end
        end
    end

    task automatic run_op(input bit use8, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] cnt, input logic [W-1:0] exp_res, input bit exp_err,
                          input int exp_cyc, input int gap, input int poke, input string tag);
        int   cycles;
        int   busy_n;
        exp_t e;
        @(negedge clock);
        repeat (gap) @(negedge clock);
        e.res = exp_res;
        e.err = exp_err;
        if (use8) begin
            start8 = 1'b1; op8 = op; a8 = a; c8 = cnt;
            q8.push_back(e);
        end else begin
            start1 = 1'b1; op1 = op; a1 = a; c1 = cnt;
            q1.push_back(e);
        end
        @(posedge clock);
        #1;
        start1 = 1'b0;
        start8 = 1'b0;
        cycles = 0;
        busy_n = 0;
        while (!(use8 ? done8 : done1) && cycles < 100) begin
            if (use8 ? busy8 : busy1) busy_n++;
            if (!use8 && poke != 0 && cycles == poke) begin
                start1 = 1'b1; op1 = 3'b100; a1 = '1; c1 = W'(1);
            end else begin
                start1 = 1'b0;
            end
            @(posedge clock);
            #1;
            cycles++;
        end
        start1 = 1'b0;
        check({tag, "_done_seen"}, W'(use8 ? done8 : done1), W'(1));
        check({tag, "_latency"}, W'(cycles), W'(exp_cyc));
        check({tag, "_busy_cycles"}, W'(busy_n), W'(exp_cyc));
    endtask

    initial begin
        clear1 = 1'b0; start1 = 1'b0; op1 = '0; a1 = '0; c1 = '0;
        clear8 = 1'b0; start8 = 1'b0; op8 = '0; a8 = '0; c8 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", W'(busy1), W'(0));
        check("rst_done", W'(done1), W'(0));
        check("rst_op_err", W'(err1), W'(0));
        check("rst_result", res1, W'(0));
        check("rst8_busy", W'(busy8), W'(0));
        @(negedge clock);
        clear1 = 1'b1;
        clear8 = 1'b1;

        run_op(0, 3'b000, 32'h0000_0012, 32'd4,   32'h0000_0001, 0, 4,  1, 0, "shr4");
        run_op(0, 3'b001, 32'h8000_0000, 32'd4,   32'hF800_0000, 0, 4,  0, 0, "shra4_b2b");
        run_op(0, 3'b001, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 0, 32, 2, 0, "shra100");
        run_op(0, 3'b100, 32'h8000_0001, 32'd33,  32'h0000_0003, 0, 1,  0, 0, "rol33");
        run_op(0, 3'b011, 32'h0000_0001, 32'd0,   32'h0000_0001, 0, 0,  1, 0, "ror0");
        run_op(0, 3'b111, 32'hDEAD_BEEF, 32'd5,   32'hDEAD_BEEF, 1, 0,  1, 0, "illegal");
        @(posedge clock);
        #1;
        check("op_err_clears", W'(err1), W'(0));
        check("done_one_cycle", W'(done1), W'(0));
        check("result_held", res1, 32'hDEAD_BEEF);
        run_op(0, 3'b010, 32'h0000_0001, 32'd40,  32'h0000_0000, 0, 32, 1, 0, "shl40");
        run_op(0, 3'b011, 32'h0000_0001, 32'd1,   32'h8000_0000, 0, 1,  1, 0, "ror1");
        run_op(0, 3'b000, 32'h0000_00F0, 32'd4,   32'h0000_000F, 0, 4,  1, 1, "shr_poke");
        run_op(0, 3'b000, 32'h0000_0055, 32'd0,   32'h0000_0055, 0, 0,  0, 0, "shr0_b2b");

        run_op(1, 3'b010, 32'h0000_00FF, 32'd20,  32'h0FF0_0000, 0, 3,  1, 0, "s8_shl20");
        run_op(1, 3'b000, 32'hFFFF_FFFF, 32'd8,   32'h00FF_FFFF, 0, 1,  0, 0, "s8_shr8");
        run_op(1, 3'b100, 32'h1234_5678, 32'd12,  32'h4567_8123, 0, 2,  1, 0, "s8_rol12");
        run_op(1, 3'b001, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 0, 4,  1, 0, "s8_shra100");

        // Asynchronous clear in the second SHIFT cycle.
        @(negedge clock);
        start1 = 1'b1; op1 = 3'b000; a1 = 32'h0000_FFFF; c1 = 32'd10;
        @(posedge clock);
        #1;
        start1 = 1'b0;
        @(posedge clock);
        #2;
        clear1 = 1'b0;
        #1;
        check("midop_rst_busy", W'(busy1), W'(0));
        check("midop_rst_done", W'(done1), W'(0));
        check("midop_rst_op_err", W'(err1), W'(0));
        check("midop_rst_result", res1, W'(0));
        @(negedge clock);
        clear1 = 1'b1;
        run_op(0, 3'b000, 32'h0000_0012, 32'd1, 32'h0000_0009, 0, 1, 1, 0, "after_reset");

        repeat (3) @(negedge clock);
        check("q1_drained", W'(q1.size()), W'(0));
        check("q8_drained", W'(q8.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
